// File: rtl/vga_frame_timer.sv
// vga_frame_timer: pixel-rate divider plus VGA raster counters.
// Produces h/v counters, registered active-low syncs, the visible-area flag
// and a one-clk frame strobe at the start of vertical blanking.
module vga_frame_timer #(
   parameter int CLK_DIV   = 4,
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic        clk,
   input  logic        reset,      // asynchronous, active low
   output logic        pix_tick,
   output logic [9:0]  h_cnt,
   output logic [9:0]  v_cnt,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic        frame,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [4:0] DIV_MAX  = 5'(CLK_DIV - 1);
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [4:0]  div_q, div_d;
   logic [9:0]  h_q, h_d;
   logic [9:0]  v_q, v_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        frame_q, frame_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic        tick;
   logic        h_wrap;

   // Tick decoded straight from the divider register; with CLK_DIV=1 the
   // divider never leaves 0, so the tick is also high throughout reset.
   assign tick   = (div_q == DIV_MAX);
   assign h_wrap = tick && (h_q == H_LAST);

   // Next-state for divider, counters, syncs and frame strobe. Syncs and
   // strobe look at the next counter values so they move on the same edge.
   always_comb begin
      div_d       = tick ? 5'd0 : div_q + 5'd1;
      h_d         = h_q;
      v_d         = v_q;
      if (tick) begin
         h_d = h_wrap ? 10'd0 : h_q + 10'd1;
      end
      if (h_wrap) begin
         v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end
      hsync_d     = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
      vsync_d     = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
      // Only the wrap edge lands on (0, V_VISIBLE), so the pulse is one clk
      // long regardless of how many clks each pixel lasts.
      frame_d     = h_wrap && (v_d == V_VIS);
      frame_cnt_d = frame_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_q       <= 5'd0;
         h_q         <= 10'd0;
         v_q         <= 10'd0;
         hsync_q     <= 1'b1;
         vsync_q     <= 1'b1;
         frame_q     <= 1'b0;
         frame_cnt_q <= 16'd0;
      end else begin
         div_q       <= div_d;
         h_q         <= h_d;
         v_q         <= v_d;
         hsync_q     <= hsync_d;
         vsync_q     <= vsync_d;
         frame_q     <= frame_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign pix_tick  = tick;
   assign h_cnt     = h_q;
   assign v_cnt     = v_q;
   assign hsync     = hsync_q;
   assign vsync     = vsync_q;
   assign video_on  = (h_q < H_VIS) && (v_q < V_VIS);
   assign frame     = frame_q;
   assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_frame_timer.sv
// Bench for vga_frame_timer using a shrunken raster so whole frames fit in
// a short run: H = 8/2/3/3 (16 px), V = 6/2/2/2 (12 lines).
//   CLK_DIV=4: line 64 clk, frame 768 clk, first frame at edge 384,
//              hsync low h 10..12 (edges 40..51), vsync low v 8..9 (512..639).
//   CLK_DIV=1: frame 192 clk, first frame at edge 96.
module tb_vga_frame_timer;

   typedef struct { int cyc; logic lvl; } edge_t;
   typedef struct { int cyc; logic [9:0] v; logic [15:0] fc; } frame_t;

   logic        clk = 1'b0;
   logic        reset, reset1;
   logic        pix_tick, hsync, vsync, video_on, frame;
   logic [9:0]  h_cnt, v_cnt;
   logic [15:0] frame_cnt;
   logic        pix_tick1, hsync1, vsync1, video_on1, frame1;
   logic [9:0]  h_cnt1, v_cnt1;
   logic [15:0] frame_cnt1;

   int checks = 0;
   int failures = 0;
   int cyc, cyc1;
   logic prev_hs = 1'b1, prev_vs = 1'b1;

   edge_t  hs_q[$], vs_q[$];
   frame_t fr_q[$], fr1_q[$];

   vga_frame_timer #(
      .CLK_DIV(4), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
   ) u_dut (
      .clk(clk), .reset(reset), .pix_tick(pix_tick), .h_cnt(h_cnt),
      .v_cnt(v_cnt), .hsync(hsync), .vsync(vsync), .video_on(video_on),
      .frame(frame), .frame_cnt(frame_cnt)
   );

   vga_frame_timer #(
      .CLK_DIV(1), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
      .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
   ) u_dut1 (
      .clk(clk), .reset(reset1), .pix_tick(pix_tick1), .h_cnt(h_cnt1),
      .v_cnt(v_cnt1), .hsync(hsync1), .vsync(vsync1), .video_on(video_on1),
      .frame(frame1), .frame_cnt(frame_cnt1)
   );

   always #5 clk = ~clk;

   // Edges since the most recent reset release, per instance.
   always @(posedge clk or negedge reset)
      if (!reset) cyc <= 0; else cyc <= cyc + 1;
   always @(posedge clk or negedge reset1)
      if (!reset1) cyc1 <= 0; else cyc1 <= cyc1 + 1;

   task automatic cmp(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   // Monitor: pops the expected event whenever the DUT shows one.
   always @(negedge clk) begin
      edge_t  e;
      frame_t f;
      if (reset) begin
         if (frame) begin
            if (fr_q.size() == 0) cmp("frame_unexpected_at_cyc", cyc, -1);
            else begin
               f = fr_q.pop_front();
               cmp("frame_cyc", cyc, f.cyc);
               cmp("frame_v_cnt", v_cnt, f.v);
               cmp("frame_h_cnt", h_cnt, 0);
               cmp("frame_cnt", frame_cnt, f.fc);
            end
         end
         if (hsync !== prev_hs && cyc < 128) begin
            if (hs_q.size() == 0) cmp("hsync_unexpected_at_cyc", cyc, -1);
            else begin
               e = hs_q.pop_front();
               cmp("hsync_edge_cyc", cyc, e.cyc);
               cmp("hsync_level", hsync, e.lvl);
            end
         end
         if (vsync !== prev_vs) begin
            if (vs_q.size() == 0) cmp("vsync_unexpected_at_cyc", cyc, -1);
            else begin
               e = vs_q.pop_front();
               cmp("vsync_edge_cyc", cyc, e.cyc);
               cmp("vsync_level", vsync, e.lvl);
            end
         end
      end
      if (reset1 && frame1) begin
         if (fr1_q.size() == 0) cmp("frame1_unexpected_at_cyc", cyc1, -1);
         else begin
            f = fr1_q.pop_front();
            cmp("frame1_cyc", cyc1, f.cyc);
            cmp("frame1_v_cnt", v_cnt1, f.v);
            cmp("frame1_cnt", frame_cnt1, f.fc);
         end
      end
      prev_hs = hsync;
      prev_vs = vsync;
   end

   task automatic push_line_syncs();
      hs_q.push_back('{40, 1'b0});
      hs_q.push_back('{52, 1'b1});
      hs_q.push_back('{104, 1'b0});
      hs_q.push_back('{116, 1'b1});
   endtask

   task automatic wait_drain(input string nm, input int budget);
      int n = 0;
      while ((fr_q.size() + vs_q.size() + hs_q.size() + fr1_q.size()) != 0
             && n < budget) begin
         @(negedge clk);
         n++;
      end
      cmp({nm, "_pending_events"},
          fr_q.size() + vs_q.size() + hs_q.size() + fr1_q.size(), 0);
   endtask

   task automatic wait_cyc(input int target);
      int n = 0;
      while (cyc != target && n < 5000) begin
         @(negedge clk);
         n++;
      end
      cmp("reached_cyc", cyc, target);
   endtask

   initial begin
      int n;
      reset  = 1'b0;
      reset1 = 1'b0;
      repeat (5) @(negedge clk);

      // Reset values for both instances.
      cmp("rst_pix_tick", pix_tick, 0);
      cmp("rst_h_cnt", h_cnt, 0);
      cmp("rst_v_cnt", v_cnt, 0);
      cmp("rst_hsync", hsync, 1);
      cmp("rst_vsync", vsync, 1);
      cmp("rst_video_on", video_on, 1);
      cmp("rst_frame", frame, 0);
      cmp("rst_frame_cnt", frame_cnt, 0);
      cmp("rst_div1_pix_tick", pix_tick1, 1);
      cmp("rst_div1_h_cnt", h_cnt1, 0);

      push_line_syncs();
      fr_q.push_back('{384, 10'd6, 16'd1});
      fr_q.push_back('{1152, 10'd6, 16'd2});
      vs_q.push_back('{512, 1'b0});
      vs_q.push_back('{640, 1'b1});
      vs_q.push_back('{1280, 1'b0});
      vs_q.push_back('{1408, 1'b1});
      reset = 1'b1;

      // Divider: tick after edges 3, 7, 11.
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         cmp("pix_tick_cycle", pix_tick, (i % 4 == 3) ? 1 : 0);
      end

      wait_cyc(31);
      cmp("h_cnt_last_visible", h_cnt, 7);
      cmp("video_on_last_visible", video_on, 1);
      @(negedge clk);
      cmp("h_cnt_first_blank", h_cnt, 8);
      cmp("video_on_first_blank", video_on, 0);

      wait_cyc(63);
      cmp("h_cnt_before_wrap", h_cnt, 15);
      cmp("v_cnt_before_wrap", v_cnt, 0);
      @(negedge clk);
      cmp("h_cnt_after_wrap", h_cnt, 0);
      cmp("v_cnt_after_wrap", v_cnt, 1);

      wait_drain("two_frames", 2000);

      // Asynchronous reset mid-frame, between clock edges.
      n = 0;
      while (!(v_cnt == 10'd3 && h_cnt == 10'd2) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      cmp("found_v3_h2", (v_cnt == 10'd3 && h_cnt == 10'd2) ? 1 : 0, 1);
      #1 reset = 1'b0;
      #1;
      cmp("mid_rst_h_cnt", h_cnt, 0);
      cmp("mid_rst_v_cnt", v_cnt, 0);
      cmp("mid_rst_frame", frame, 0);
      cmp("mid_rst_frame_cnt", frame_cnt, 0);
      cmp("mid_rst_pix_tick", pix_tick, 0);
      cmp("mid_rst_video_on", video_on, 1);
      reset = 1'b1;
      push_line_syncs();
      fr_q.push_back('{384, 10'd6, 16'd1});
      vs_q.push_back('{512, 1'b0});
      vs_q.push_back('{640, 1'b1});
      wait_drain("after_mid_reset", 1000);

      // CLK_DIV = 1: tick every cycle, 192-cycle frame.
      fr1_q.push_back('{96, 10'd6, 16'd1});
      fr1_q.push_back('{288, 10'd6, 16'd2});
      @(negedge clk);
      reset1 = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         cmp("div1_pix_tick", pix_tick1, 1);
         cmp("div1_h_cnt", h_cnt1, i);
      end
      wait_drain("div1_frames", 600);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vga_frame_timer.md
# vga_frame_timer

Raster timing source for the osmosis display pipeline. It divides the system clock down to a pixel rate and generates 640x480 VGA timing: `h_cnt`, `v_cnt`, active-low syncs and `video_on`. It also produces the one-cycle `frame` strobe that the molecule blocks use to advance positions once per frame. It sits directly upstream of every `molecule_*` instance and the pixel colour mux.

## Interface
- `CLK_DIV`, 4: clk cycles per pixel; legal range 1..16.
- `H_VISIBLE`, 640; `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48. Horizontal segments in pixels; H_TOTAL = sum = 800.
- `V_VISIBLE`, 480; `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33. Vertical segments in lines; V_TOTAL = sum = 525.

Ports:
- `clk` in 1: system clock (100 MHz).
- `reset` in 1: asynchronous, active-low reset; the block is held in reset while 0.
- `pix_tick` out 1: high for one clk cycle, once every CLK_DIV cycles.
- `h_cnt` out 10: pixel column, 0..H_TOTAL-1.
- `v_cnt` out 10: line, 0..V_TOTAL-1.
- `hsync` out 1: active-low horizontal sync.
- `vsync` out 1: active-low vertical sync.
- `video_on` out 1: high when `h_cnt` < H_VISIBLE and `v_cnt` < V_VISIBLE.
- `frame` out 1: one-clk pulse at the start of vertical blanking.
- `frame_cnt` out 16: count of `frame` pulses since reset; wraps modulo 2^16.

## Operation
- **Divider.**
  - `div_cnt` counts 0..CLK_DIV-1 and wraps.
  - `pix_tick` = (`div_cnt` == CLK_DIV-1), decoded from the register.
  - When CLK_DIV = 1, `pix_tick` is 1 in every cycle out of reset.
- **Horizontal counter.**
  - Advances on the clk edge where `pix_tick` = 1.
  - H_TOTAL-1 wraps to 0.
- **Vertical counter.**
  - Advances only on the edge where `h_cnt` wraps.
  - V_TOTAL-1 wraps to 0. The counters therefore step together from (799,524) to (0,0).
- **Syncs.**
  - Registered. They are computed from the next counter values, so they change on the same edge as the counters.
  - `hsync` = 0 iff `h_cnt` is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1], which is [656,751].
  - `vsync` = 0 iff `v_cnt` is in [490,491].
- **Visible region.** `video_on` is combinational from the registered counters.
- **Frame strobe.**
  - `frame` is registered and goes high on the edge where the counters become (0,V_VISIBLE) = (0,480).
  - It is high for exactly one clk cycle, even when CLK_DIV > 1.
  - `frame_cnt` increments on the same edge `frame` rises, and wraps from 0xFFFF to 0.
- **Reset values.**
  - `div_cnt`=0, `h_cnt`=0, `v_cnt`=0, `hsync`=1, `vsync`=1, `frame`=0, `frame_cnt`=0.
  - `pix_tick`=0 when CLK_DIV > 1 and 1 when CLK_DIV = 1.
  - `video_on`=1, since (0,0) is visible.
- **Reset mid-frame.** Asserting `reset` forces all of the above values immediately, independent of `clk`. After release, counting restarts from (0,0) with `div_cnt`=0. No partial `frame` pulse is produced.
- **No back-pressure.** The block has no inputs other than `clk` and `reset`, and never stalls.

## Timing
- **First tick.** The first `pix_tick` occurs in cycle CLK_DIV-1 after reset release.
- **Line period.** H_TOTAL x CLK_DIV = 3200 clk cycles.
- **Frame period.** H_TOTAL x V_TOTAL x CLK_DIV = 1,680,000 clk cycles.
- **First frame pulse.** Rises 480 x 800 x 4 = 1,536,000 clk edges after reset release.
- **Sync widths.**
  - `hsync` low for H_SYNC x CLK_DIV = 384 clk cycles per line.
  - `vsync` low for 2 x 3200 = 6400 clk cycles.
- **Sync alignment.** Counter updates and sync edges are coincident. There is zero-cycle skew between `h_cnt`/`v_cnt` and `hsync`/`vsync`/`video_on`.
- **Frame vs blanking.** `frame` leads the vertical front porch by 0 cycles and precedes `vsync` falling by 10 lines (32,000 clk).

## Test plan
- **Reset values.** Hold `reset`=0 for 5 cycles -> every output equals its reset value, including `video_on`=1 and `hsync`=`vsync`=1.
- **Divider and horizontal wrap.** Release reset with CLK_DIV=4 -> `pix_tick` is high in cycles 3, 7, 11… Then `h_cnt` goes 799 -> 0 and `v_cnt` goes 0 -> 1 at clk edge 3200.
- **Horizontal sync.** Observe one line -> `hsync` falls when `h_cnt` becomes 656 and rises when it becomes 752, so it is low for 384 cycles. `video_on` drops when `h_cnt` becomes 640.
- **Frame strobe and vertical sync.**
  - `frame` is high for exactly 1 cycle at edge 1,536,000, with `v_cnt`=480 and `frame_cnt`=1.
  - `vsync` is low for `v_cnt` = 490..491.
  - The next `frame` arrives 1,680,000 cycles later with `frame_cnt`=2.
- **Asynchronous reset mid-frame.** Pulse `reset` low for 1 ns between clk edges at `v_cnt`=300 -> counters read 0 immediately, with no `frame` pulse. The first `frame` then arrives 1,536,000 edges after release.
- **CLK_DIV=1 variant.** `pix_tick` is constantly 1 and the frame period is 420,000 cycles. Force `frame_cnt` to 0xFFFF -> the next `frame` wraps it to 0x0000.
